qupls_cache_fill: RTL and testbench
===================================

QUPLS_CACHE_FILL -- requirements
Module: Qupls_cache_fill

Interface
REQ-001 The block SHALL have parameter LINES, default 256, giving the number of cache lines (sets) per way.
REQ-002 The block SHALL have parameter WAYS, default 4, giving the number of ways (max 4).
REQ-003 The block SHALL have parameter TAGBIT, default 14, giving the lowest address bit that forms the tag.
REQ-004 The block SHALL have port rst, input, 1 bit: reset; one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port fill_req, input, 1 bit: level request to allocate a way for fill_adr.
REQ-007 The block SHALL have port fill_adr, input, cpu_types_pkg::address_t: refill address; index = fill_adr[TAGBIT-1 -: $clog2(LINES)], tag = fill_adr[msb:TAGBIT].
REQ-008 The block SHALL have port fill_ack, output, 1 bit: one-cycle pulse, allocation performed.
REQ-009 The block SHALL have port fill_way, output, 2 bits: way selected for the current fill.
REQ-010 The block SHALL have port tag_we, output, WAYS bits: one-hot tag-RAM write enable.
REQ-011 The block SHALL have port tag_ndx, output, $clog2(LINES) bits: tag-RAM write index.
REQ-012 The block SHALL have port tag_o, output, cache_tag_t: tag value to write.
REQ-013 The block SHALL have port inv_line, input, 1 bit: invalidate one way of one line.
REQ-014 The block SHALL have port inv_adr, input, address_t: address whose index is invalidated.
REQ-015 The block SHALL have port inv_way, input, 2 bits: way to invalidate.
REQ-016 The block SHALL have port inv_all, input, 1 bit: start full-cache invalidate sweep.
REQ-017 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-018 The block SHALL have port valid, output, [LINES-1:0] [0:WAYS-1]: valid bits, same shape as the hit detector's valid input.

Function
REQ-019 The block SHALL implement states IDLE, WRITE, INVALL.
REQ-020 In IDLE, priority SHALL be inv_all > fill_req; inv_line is independent.
REQ-021 IDLE with fill_req=1 at edge k: latch index/tag, compute victim, go WRITE.
REQ-022 Victim SHALL be the lowest-numbered way with valid=0 at the index; if all ways are valid, the victim is that line's 2-bit round-robin counter value, and the counter increments mod WAYS.
REQ-023 In WRITE (one cycle), fill_ack=1, tag_we=onehot(fill_way), tag_ndx/tag_o = latched values; at the ending edge set valid[fill_way][ndx]=1 and return to IDLE.
REQ-024 Fill latency SHALL be exactly one cycle from the sampling edge to fill_ack; fill_req is not sampled in WRITE; the requester drops fill_req in the cycle after fill_ack.
REQ-025 fill_adr SHALL be sampled only at the accepting edge; later changes do not affect the fill.
REQ-026 Outside WRITE, tag_we SHALL be 0 and fill_ack 0; fill_way/tag_ndx/tag_o hold their last values.
REQ-027 inv_line=1 in IDLE or WRITE SHALL clear valid[inv_way][inv index] at that edge.
REQ-028 If inv_line and a WRITE-state valid set target the same bit on the same edge, the clear SHALL win.
REQ-029 inv_line SHALL be ignored in INVALL.
REQ-030 inv_all in IDLE SHALL enter INVALL; a sweep counter from 0 clears all ways of one line and that line's round-robin counter per cycle.
REQ-031 After line LINES-1 is cleared, the block SHALL return to IDLE; the sweep takes exactly LINES cycles, with busy=1 for all of them.
REQ-032 fill_req and inv_all SHALL be ignored during INVALL; fill_req still high on return to IDLE is then accepted.
REQ-033 inv_all arriving in WRITE SHALL be taken after WRITE completes, if still asserted in IDLE.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE, all valid=0, all round-robin counters=0, sweep counter=0, fill_ack=0, tag_we=0, busy=0, fill_way=0, tag_ndx=0, tag_o=0.
REQ-035 Reset in WRITE or INVALL SHALL abort the operation; no valid bit is set by the aborted fill.

Verification
REQ-036 The bench SHALL cover: after reset, fill_req with fill_adr=0x0001_4000 (LINES=256) -> next cycle fill_ack=1, fill_way=0, tag_we=0001, tag_ndx=0x00, tag_o=0x5, valid[0][0]=1.
REQ-037 The bench SHALL cover: five fills to index 3 with distinct tags -> ways 0,1,2,3, then way 0 on the fifth (round-robin), then way 1 on a sixth.
REQ-038 The bench SHALL cover: ways 0-3 valid at index 7; inv_line way 2 index 7; then fill to index 7 -> fill_way=2.
REQ-039 The bench SHALL cover: inv_line to index 5 way 0 on the same edge a WRITE sets valid[0][5] -> valid[0][5]=0.
REQ-040 The bench SHALL cover: inv_all with fill_req held high -> busy=1 for exactly 256 cycles, all valid=0, then fill accepted and fill_ack returned one cycle later.
REQ-041 The bench SHALL cover: rst asserted on sweep cycle 100 -> next cycle busy=0, state IDLE, all valid=0.

Source files
------------

// File: rtl/qupls_cache_fill.sv
// Cache refill way allocator: picks a victim way per line, drives the tag-RAM write,
// and owns the per-line valid bits and round-robin counters, including a full invalidate sweep.
module qupls_cache_fill #(
  parameter int LINES  = 256,
  parameter int WAYS   = 4,
  parameter int TAGBIT = 14,
  parameter int AW     = 32,
  localparam int NDXW  = $clog2(LINES),
  localparam int TAGW  = AW - TAGBIT
) (
  input  logic                            rst,
  input  logic                            clk,
  input  logic                            fill_req,
  input  logic [AW-1:0]                   fill_adr,
  output logic                            fill_ack,
  output logic [1:0]                      fill_way,
  output logic [WAYS-1:0]                 tag_we,
  output logic [NDXW-1:0]                 tag_ndx,
  output logic [TAGW-1:0]                 tag_o,
  input  logic                            inv_line,
  input  logic [AW-1:0]                   inv_adr,
  input  logic [1:0]                      inv_way,
  input  logic                            inv_all,
  output logic                            busy,
  output logic [LINES-1:0][0:WAYS-1]      valid
);

  typedef enum logic [1:0] {IDLE, WRITE, INVALL} state_t;

  localparam logic [NDXW-1:0] LAST_LINE = NDXW'(LINES - 1);
  localparam logic [1:0]      LAST_WAY  = 2'(WAYS - 1);

  state_t state_q, state_d;

  logic [LINES-1:0][0:WAYS-1] valid_q;
  logic [LINES-1:0][1:0]      rr_q;
  logic [NDXW-1:0]            sweep_q;
  logic [1:0]                 way_q;
  logic [NDXW-1:0]            ndx_q;
  logic [TAGW-1:0]            tag_q;

  logic [NDXW-1:0] req_ndx, inv_ndx;
  logic [1:0]      victim, rr_next;
  logic            all_valid;
  logic            accept;

  assign req_ndx = fill_adr[TAGBIT-1 -: NDXW];
  assign inv_ndx = inv_adr[TAGBIT-1 -: NDXW];
  assign accept  = (state_q == IDLE) && !inv_all && fill_req;

  logic unused_adr_bits;
  assign unused_adr_bits = ^{fill_adr[TAGBIT-NDXW-1:0], inv_adr[TAGBIT-NDXW-1:0], inv_adr[AW-1:TAGBIT]};

  // Lowest invalid way wins; the descending scan leaves the smallest index in victim.
  always_comb begin
    victim    = rr_q[req_ndx];
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_ndx][w]) begin
        victim    = 2'(w);
        all_valid = 1'b0;
      end
    end
    rr_next = (rr_q[req_ndx] == LAST_WAY) ? 2'd0 : rr_q[req_ndx] + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (inv_all) state_d = INVALL;
               else if (fill_req) state_d = WRITE;
      WRITE:   state_d = IDLE;
      INVALL:  if (sweep_q == LAST_LINE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_ack = 1'b0;
    tag_we   = '0;
    busy     = 1'b0;
    case (state_q)
      WRITE: begin
        fill_ack       = 1'b1;
        tag_we[way_q]  = 1'b1;
      end
      INVALL:  busy = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      rr_q    <= '0;
      sweep_q <= '0;
      way_q   <= '0;
      ndx_q   <= '0;
      tag_q   <= '0;
    end else begin
      if (accept) begin
        way_q <= victim;
        ndx_q <= req_ndx;
        tag_q <= fill_adr[AW-1:TAGBIT];
        if (all_valid) rr_q[req_ndx] <= rr_next;
      end
      if (state_q == WRITE) valid_q[ndx_q][way_q] <= 1'b1;
      if (state_q == INVALL) begin
        valid_q[sweep_q] <= '0;
        rr_q[sweep_q]    <= '0;
        sweep_q          <= (sweep_q == LAST_LINE) ? '0 : sweep_q + NDXW'(1);
      end
      // Placed last so a same-edge invalidate beats the WRITE-state set.
      if (inv_line && state_q != INVALL) valid_q[inv_ndx][inv_way] <= 1'b0;
    end
  end

  assign fill_way = way_q;
  assign tag_ndx  = ndx_q;
  assign tag_o    = tag_q;
  assign valid    = valid_q;

endmodule

// File: tb/tb_qupls_cache_fill.sv
// Directed bench for qupls_cache_fill: fills, round-robin replacement, line and full invalidate, reset abort.
module tb_qupls_cache_fill;

  logic                 rst, clk;
  logic                 fill_req;
  logic [31:0]          fill_adr;
  logic                 fill_ack;
  logic [1:0]           fill_way;
  logic [3:0]           tag_we;
  logic [7:0]           tag_ndx;
  logic [17:0]          tag_o;
  logic                 inv_line;
  logic [31:0]          inv_adr;
  logic [1:0]           inv_way;
  logic                 inv_all;
  logic                 busy;
  logic [255:0][0:3]    valid;

  int vectors = 0;
  int miscompares = 0;

  qupls_cache_fill dut (
    .rst(rst), .clk(clk), .fill_req(fill_req), .fill_adr(fill_adr),
    .fill_ack(fill_ack), .fill_way(fill_way), .tag_we(tag_we), .tag_ndx(tag_ndx),
    .tag_o(tag_o), .inv_line(inv_line), .inv_adr(inv_adr), .inv_way(inv_way),
    .inv_all(inv_all), .busy(busy), .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mkadr(input int tag, input int ndx);
    return (32'(tag) << 14) | (32'(ndx) << 6);
  endfunction

  // Requester holds fill_req through the ack cycle and drops it the cycle after.
  task automatic do_fill(input string tag, input logic [31:0] adr, input logic [1:0] exp_way);
    logic [7:0] n;
    n = adr[13:6];
    fill_req = 1'b1;
    fill_adr = adr;
    tick();
    check({tag, "_ack"}, 32'(fill_ack), 32'd1);
    check({tag, "_way"}, 32'(fill_way), 32'(exp_way));
    check({tag, "_we"},  32'(tag_we), 32'(4'b0001 << exp_way));
    check({tag, "_ndx"}, 32'(tag_ndx), 32'(n));
    check({tag, "_tag"}, 32'(tag_o), 32'(adr[31:14]));
    fill_adr = 32'hdead_beef;
    tick();
    fill_req = 1'b0;
    check({tag, "_ack_drop"}, 32'(fill_ack), 32'd0);
    check({tag, "_valid"}, 32'(valid[n][exp_way]), 32'd1);
  endtask

  initial begin
    int cnt;
    logic [1:0] exp_rr [6];
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst = 1'b1; fill_req = 1'b0; fill_adr = '0; inv_line = 1'b0;
    inv_adr = '0; inv_way = '0; inv_all = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_ack",   32'(fill_ack), 32'd0);
    check("rst_we",    32'(tag_we), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_way",   32'(fill_way), 32'd0);
    check("rst_ndx",   32'(tag_ndx), 32'd0);
    check("rst_tag",   32'(tag_o), 32'd0);
    check("rst_valid", 32'(|valid), 32'd0);

    do_fill("first", 32'h0001_4000, 2'd0);
    check("first_tag5", 32'(tag_o), 32'h5);
    check("first_v00",  32'(valid[0][0]), 32'd1);

    for (int i = 0; i < 6; i++)
      do_fill($sformatf("rr%0d", i), mkadr(i + 1, 3), exp_rr[i]);

    for (int i = 0; i < 4; i++)
      do_fill($sformatf("n7_%0d", i), mkadr(i + 10, 7), 2'(i));
    inv_line = 1'b1; inv_adr = mkadr(99, 7); inv_way = 2'd2;
    tick();
    inv_line = 1'b0;
    check("inv7_cleared", 32'(valid[7][2]), 32'd0);
    check("inv7_kept",    32'(valid[7][3]), 32'd1);
    do_fill("refill7", mkadr(20, 7), 2'd2);

    fill_req = 1'b1; fill_adr = mkadr(30, 5);
    tick();
    check("race_ack", 32'(fill_ack), 32'd1);
    check("race_way", 32'(fill_way), 32'd0);
    inv_line = 1'b1; inv_adr = mkadr(1, 5); inv_way = 2'd0;
    tick();
    fill_req = 1'b0; inv_line = 1'b0;
    check("race_clear_wins", 32'(valid[5][0]), 32'd0);

    fill_req = 1'b1; fill_adr = mkadr(40, 9); inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    check("sweep_busy", 32'(busy), 32'd1);
    check("sweep_no_ack", 32'(fill_ack), 32'd0);
    cnt = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      cnt++;
      tick();
    end
    check("sweep_len", 32'(cnt), 32'd256);
    check("sweep_cleared", 32'(|valid), 32'd0);
    check("sweep_idle_ack", 32'(fill_ack), 32'd0);
    tick();
    check("post_sweep_ack", 32'(fill_ack), 32'd1);
    check("post_sweep_way", 32'(fill_way), 32'd0);
    check("post_sweep_ndx", 32'(tag_ndx), 32'd9);
    tick();
    fill_req = 1'b0;
    check("post_sweep_valid", 32'(valid[9][0]), 32'd1);

    do_fill("pre_abort", mkadr(50, 12), 2'd0);
    inv_all = 1'b1;
    tick();
    inv_all = 1'b0;
    for (int i = 0; i < 99; i++) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(|valid), 32'd0);
    do_fill("after_abort", mkadr(60, 12), 2'd0);

    fill_req = 1'b1; fill_adr = mkadr(70, 14);
    tick();
    fill_req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wr_abort_valid", 32'(|valid), 32'd0);
    check("wr_abort_ack", 32'(fill_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
